// File: rtl/branch_ctrl.sv
// Branch control for the PC: decodes the branch op, owns the condition flag,
// the jump-target LUT and a circular return-address stack for CALL/RET.
module branch_ctrl #(
    parameter int D         = 12,
    parameter int LUT_AW    = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic [D-1:0]      prog_ctr,
    input  logic              flag_we,
    input  logic              flag_in,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    output logic [2:0]        branch,
    output logic              jcnd,
    output logic [D-1:0]      target,
    output logic              taken,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int RAS_AW = $clog2(RAS_DEPTH);
    localparam int LUT_N  = 2 ** LUT_AW;
    localparam logic [RAS_AW:0]   RAS_FULL = (RAS_AW + 1)'(RAS_DEPTH);
    localparam logic [RAS_AW-1:0] PTR_ONE  = RAS_AW'(1);
    localparam logic [RAS_AW:0]   CNT_ONE  = (RAS_AW + 1)'(1);
    localparam logic [D-1:0]      PC_ONE   = D'(1);

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BT   = 3'b001,
        OP_BF   = 3'b010,
        OP_JMP  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    localparam logic [2:0] BR_INC  = 3'b000;
    localparam logic [2:0] BR_JT   = 3'b001;
    localparam logic [2:0] BR_JF   = 3'b010;
    localparam logic [2:0] BR_JMP  = 3'b011;

    logic              flag;
    logic [D-1:0]      lut [LUT_N];
    logic [D-1:0]      ras [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_ptr;   // next slot to push into
    logic [RAS_AW:0]   ras_cnt;
    logic              ras_empty;
    logic              ras_full;
    logic [D-1:0]      ras_top;
    logic [D-1:0]      lut_rd;

    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == RAS_FULL);
    assign ras_top   = ras[ras_ptr - PTR_ONE];
    assign lut_rd    = lut[lut_idx];
    assign jcnd      = flag;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        branch = BR_INC;
        target = '0;
        taken  = 1'b0;
        if (!reset) begin
            case (op)
                OP_BT: begin
                    branch = BR_JT;
                    target = lut_rd;
                    taken  = flag;
                end
                OP_BF: begin
                    branch = BR_JF;
                    target = lut_rd;
                    taken  = !flag;
                end
                OP_JMP, OP_CALL: begin
                    branch = BR_JMP;
                    target = lut_rd;
                    taken  = 1'b1;
                end
                OP_RET: begin
                    if (!ras_empty) begin
                        branch = BR_JMP;
                        target = ras_top;
                        taken  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the LUT is reset entry by entry because software may jump through
    // an entry it never wrote; RAS storage is not, since ras_cnt gates every read.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag          <= 1'b0;
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
        end else begin
            if (flag_we) flag <= flag_in;
            if (lut_we) lut[lut_waddr] <= lut_wdata;
            if (op == OP_CALL) begin
                ras_ptr <= ras_ptr + PTR_ONE;
                if (ras_full) ras_overflow <= 1'b1;
                else          ras_cnt      <= ras_cnt + CNT_ONE;
            end else if (op == OP_RET) begin
                if (ras_empty) begin
                    ras_underflow <= 1'b1;
                end else begin
                    ras_ptr <= ras_ptr - PTR_ONE;
                    ras_cnt <= ras_cnt - CNT_ONE;
                end
            end
        end
    end

    // A push when full lands on the oldest slot, which is exactly ras_ptr.
    always_ff @(posedge clk) begin
        if (!reset && op == OP_CALL) ras[ras_ptr] <= prog_ctr + PC_ONE;
    end

endmodule
